sha2_stream_hasher: RTL and testbench
=====================================

Name: sha2_stream_hasher

Overview:
Parametrised streaming SHA-224/SHA-256 engine. It is the next-generation hash top for the accelerator. It accepts a byte stream over a valid/ready interface, IN_BYTES bytes per beat, and pads it internally. It compresses one round per cycle and presents the digest on a held valid/ready output. Messages may be issued back-to-back. The digest mode is selected per message.

Parameters:
IN_BYTES, 4, bytes per input beat; legal values 1, 2, 4, 8 (must divide 64).
LEN_W, 64, message bit-length counter width, 16..64; zero-extended into the 64-bit padding length field.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
enable  input  1  0 freezes all state; s_ready forced 0; outputs hold
mode_224  input  1  1 = SHA-224, 0 = SHA-256; sampled with the first beat of a message
s_data  input  8*IN_BYTES  message bytes; first byte in the MSBs
s_nbytes  input  $clog2(IN_BYTES)+1  valid byte count on the s_last beat (0..IN_BYTES), upper-justified; ignored otherwise
s_valid  input  1  input beat valid
s_last  input  1  final beat of the message
s_ready  output  1  engine can accept a beat
hash_out  output  256  digest; SHA-224 gives {H0..H6, 32'h0}
hash_valid  output  1  digest valid; held until accepted
hash_ready  input  1  digest consumer accept
busy  output  1  high from the first accepted beat until the digest handshake completes

Behaviour:
- Reset (async, rst=1): s_ready=0, hash_valid=0, hash_out=0, busy=0, FSM=IDLE, byte and length counters=0. Reset asserted mid-message or mid-compress aborts the message with no partial output. On the first clk edge after rst deasserts, s_ready=1.
- Beat accepted when s_valid & s_ready & enable. Non-last beats must carry IN_BYTES bytes. s_last with s_nbytes=0 is legal and marks end of message; a message of only this beat is the empty message.
- FSM states:
  - IDLE: s_ready=1. First accepted beat latches mode_224, loads the IV (FIPS 180-4 224 or 256 IV) into H, goes to LOAD.
  - LOAD: s_ready=1. Bytes are appended to the 64-byte block buffer and the length counter adds 8*bytes. If the buffer reaches 64 bytes, go to COMPRESS. On s_last with the buffer not full, go to PAD.
  - PAD: 1 cycle, s_ready=0. Append 0x80, then zeros. If at least 8 bytes remain, write the 64-bit big-endian bit length into bytes 56..63 and set final=1; otherwise set final=0 and set a pending-length flag. Go to COMPRESS.
  - COMPRESS: s_ready=0. 64 cycles, one round per cycle, with a 16-word rolling message schedule. Then 1 UPDATE cycle: H += a..h, buffer cleared. Next state:
    - final=1: go to OUT.
    - Pending length: next block is all zeros plus length (and 0x80 first if s_last landed exactly on a 64-byte boundary); go to PAD.
    - Otherwise: go to LOAD.
  - OUT: hash_out registered from H, hash_valid=1, s_ready=0. On hash_valid & hash_ready, next cycle hash_valid=0, busy=0, state IDLE, s_ready=1.
- Latency: a last beat accepted at edge t, needing one block, gives hash_valid=1 after edge t+66: PAD 1, rounds 64, UPDATE 1. Each extra block adds 66 cycles. No input is accepted during PAD, COMPRESS, UPDATE or OUT.
- Outputs while hash_valid=1:
  - hash_out is stable and hash_valid does not drop without hash_ready.
  - hash_ready while hash_valid=0 is ignored.
- enable=0 in any state: no state, counter or output change, and a pending handshake is not completed. Resumes exactly where it stopped.
- Arithmetic: all round additions are mod 2^32. The length counter wraps mod 2^LEN_W.
- s_valid while s_ready=0: the beat is not consumed; the source must hold it.

Test Plan:
- SHA-256 "abc", IN_BYTES=4, one beat s_nbytes=3 s_last=1 -> after 66 cycles hash_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; hash_valid stays high with hash_ready=0 for 10 cycles.
- SHA-224 "abc", mode_224=1 -> hash_out[255:32]=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, hash_out[31:0]=0.
- Empty message (s_last, s_nbytes=0) -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 56-byte "abcdbcdecdef...nopq" at IN_BYTES=1 and IN_BYTES=8 -> two blocks, digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, hash_valid 132 cycles after last beat.
- Back-to-back "abc" (SHA-256) then "abc" (SHA-224), hash_ready held high, random s_valid gaps and enable=0 pulses -> both digests correct and in order; no beat lost or duplicated.
- rst pulsed during round 30 of the first message, then "abc" sent -> no digest from the aborted message; correct "abc" digest; all outputs 0 during reset.

Source files
------------

// File: rtl/sha2_stream_hasher.sv
// Streaming SHA-224/SHA-256 engine: byte beats in, internal padding, one round per
// clock, digest held on a valid/ready output until accepted.
module sha2_stream_hasher #(
    parameter int IN_BYTES = 4,
    parameter int LEN_W    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       mode_224,
    input  logic [8*IN_BYTES-1:0]      s_data,
    input  logic [$clog2(IN_BYTES):0]  s_nbytes,
    input  logic                       s_valid,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [255:0]               hash_out,
    output logic                       hash_valid,
    input  logic                       hash_ready,
    output logic                       busy
);

    localparam int BEAT_W = 8 * IN_BYTES;
    localparam int NBEATS = 64 / IN_BYTES;
    localparam int SH     = $clog2(IN_BYTES);
    localparam int IDX_W  = 6 - SH;

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [2:0] {IDLE, LOAD, PAD, COMPRESS, UPDATE, OUT} state_t;

    state_t             state_reg, state_next;
    logic [511:0]       blk_reg;
    logic [6:0]         cnt_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [31:0]        h_reg  [8];
    logic [31:0]        wv_reg [8];
    logic [5:0]         round_reg;
    logic               mode_reg, mark_reg, last_reg, final_reg, run_reg;
    logic [255:0]       hash_out_reg;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Handshake and status
    logic       accept;
    logic [6:0] add_bytes, cnt_sum;

    assign s_ready    = run_reg & enable & ((state_reg == IDLE) | (state_reg == LOAD));
    assign accept     = s_valid & s_ready;
    assign add_bytes  = s_last ? 7'(s_nbytes) : 7'(IN_BYTES);
    assign cnt_sum    = cnt_reg + add_bytes;
    assign hash_valid = (state_reg == OUT);
    assign hash_out   = hash_out_reg;
    assign busy       = (state_reg != IDLE);

    // Beat insertion: non-last beats are full, so the write slot is cnt/IN_BYTES
    logic [511:0]     load_blk;
    logic [IDX_W-1:0] beat_idx;
    assign beat_idx = cnt_reg[5:SH];

    genvar gi;
    generate
        for (gi = 0; gi < NBEATS; gi++) begin : g_beat
            assign load_blk[511-BEAT_W*gi -: BEAT_W] =
                (beat_idx == IDX_W'(gi)) ? s_data : blk_reg[511-BEAT_W*gi -: BEAT_W];
        end
    endgenerate

    // Padding: marker (once per message), zero fill, length if it still fits
    logic [511:0] pad_blk;
    logic [6:0]   pad_base;
    logic         len_fits;
    logic [63:0]  len64;
    assign pad_base = cnt_reg + {6'd0, ~mark_reg};
    assign len_fits = (pad_base <= 7'd56);
    assign len64    = 64'(len_reg);

    generate
        for (gi = 0; gi < 64; gi++) begin : g_pad
            logic [7:0] fill;
            assign fill = ((7'(gi) == cnt_reg) && !mark_reg) ? 8'h80 : 8'h00;
            if (gi >= 56) begin : g_len
                assign pad_blk[511-8*gi -: 8] = (7'(gi) < cnt_reg) ? blk_reg[511-8*gi -: 8] :
                                                len_fits ? len64[63-8*(gi-56) -: 8] : fill;
            end else begin : g_body
                assign pad_blk[511-8*gi -: 8] = (7'(gi) < cnt_reg) ? blk_reg[511-8*gi -: 8] : fill;
            end
        end
    endgenerate

    // Round datapath; blk_reg doubles as the 16-word rolling schedule
    logic [31:0] w0, w1, w9, w14, w_new, t1, t2, ch, maj;
    logic [31:0] h_sum [8];
    always_comb begin
        w0    = blk_reg[511:480];
        w1    = blk_reg[479:448];
        w9    = blk_reg[511-32*9 -: 32];
        w14   = blk_reg[511-32*14 -: 32];
        w_new = (rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10)) + w9
              + (rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3)) + w0;
        ch    = (wv_reg[4] & wv_reg[5]) ^ (~wv_reg[4] & wv_reg[6]);
        maj   = (wv_reg[0] & wv_reg[1]) ^ (wv_reg[0] & wv_reg[2]) ^ (wv_reg[1] & wv_reg[2]);
        t1    = wv_reg[7] + (rotr(wv_reg[4], 6) ^ rotr(wv_reg[4], 11) ^ rotr(wv_reg[4], 25))
              + ch + K_TAB[round_reg] + w0;
        t2    = (rotr(wv_reg[0], 2) ^ rotr(wv_reg[0], 13) ^ rotr(wv_reg[0], 22)) + maj;
        for (int i = 0; i < 8; i++) h_sum[i] = h_reg[i] + wv_reg[i];
    end

    always_comb begin
        state_next = state_reg;
        if (enable) begin
            case (state_reg)
                IDLE, LOAD: if (accept) begin
                    if (cnt_sum == 7'd64) state_next = COMPRESS;
                    else if (s_last)      state_next = PAD;
                    else                  state_next = LOAD;
                end
                PAD:      state_next = COMPRESS;
                COMPRESS: if (round_reg == 6'd63) state_next = UPDATE;
                UPDATE:   state_next = final_reg ? OUT : (last_reg ? PAD : LOAD);
                OUT:      if (hash_ready) state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            blk_reg      <= '0;
            cnt_reg      <= '0;
            len_reg      <= '0;
            round_reg    <= '0;
            mode_reg     <= 1'b0;
            mark_reg     <= 1'b0;
            last_reg     <= 1'b0;
            final_reg    <= 1'b0;
            run_reg      <= 1'b0;
            hash_out_reg <= '0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i]  <= '0;
                wv_reg[i] <= '0;
            end
        end else if (enable) begin
            run_reg   <= 1'b1;
            state_reg <= state_next;
            case (state_reg)
                IDLE, LOAD: if (accept) begin
                    blk_reg  <= load_blk;
                    cnt_reg  <= cnt_sum;
                    last_reg <= s_last;
                    len_reg  <= (state_reg == IDLE ? '0 : len_reg) + LEN_W'({add_bytes, 3'b000});
                    if (state_reg == IDLE) begin
                        mode_reg  <= mode_224;
                        mark_reg  <= 1'b0;
                        final_reg <= 1'b0;
                        for (int i = 0; i < 8; i++) begin
                            h_reg[i]  <= mode_224 ? IV224[i] : IV256[i];
                            wv_reg[i] <= mode_224 ? IV224[i] : IV256[i];
                        end
                    end
                end
                PAD: begin
                    blk_reg   <= pad_blk;
                    mark_reg  <= 1'b1;
                    final_reg <= len_fits;
                end
                COMPRESS: begin
                    blk_reg   <= {blk_reg[479:0], w_new};
                    round_reg <= round_reg + 6'd1;
                    wv_reg[7] <= wv_reg[6];
                    wv_reg[6] <= wv_reg[5];
                    wv_reg[5] <= wv_reg[4];
                    wv_reg[4] <= wv_reg[3] + t1;
                    wv_reg[3] <= wv_reg[2];
                    wv_reg[2] <= wv_reg[1];
                    wv_reg[1] <= wv_reg[0];
                    wv_reg[0] <= t1 + t2;
                end
                UPDATE: begin
                    blk_reg <= '0;
                    cnt_reg <= '0;
                    for (int i = 0; i < 8; i++) begin
                        h_reg[i]  <= h_sum[i];
                        wv_reg[i] <= h_sum[i];
                    end
                    if (final_reg)
                        hash_out_reg <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4],
                                         h_sum[5], h_sum[6], mode_reg ? 32'h0 : h_sum[7]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_stream_hasher.sv
// Directed bench for sha2_stream_hasher: FIPS test vectors at 1/4/8-byte beat widths,
// latency, hold, back-to-back with stalls, and reset abort.
module tb_sha2_stream_hasher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, enable = 1'b1, mode_224 = 1'b0, hash_ready = 1'b0;
    logic [63:0] s_data = '0;
    logic [3:0]  s_nbytes = '0;
    logic        s_valid = 1'b0, s_last = 1'b0;
    int          sel = 0;   // 0: 4-byte DUT, 1: 1-byte DUT, 2: 8-byte DUT

    logic         rdy4, rdy1, rdy8, hv4, hv1, hv8, bz4, bz1, bz8;
    logic [255:0] ho4, ho1, ho8;
    logic         rdy_m, hv_m, bz_m;
    logic [255:0] ho_m;

    sha2_stream_hasher #(.IN_BYTES(4), .LEN_W(64)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .mode_224(mode_224),
        .s_data(s_data[31:0]), .s_nbytes(s_nbytes[2:0]), .s_valid(s_valid && sel == 0),
        .s_last(s_last), .s_ready(rdy4), .hash_out(ho4), .hash_valid(hv4),
        .hash_ready(hash_ready), .busy(bz4));
    sha2_stream_hasher #(.IN_BYTES(1), .LEN_W(32)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .mode_224(mode_224),
        .s_data(s_data[7:0]), .s_nbytes(s_nbytes[0:0]), .s_valid(s_valid && sel == 1),
        .s_last(s_last), .s_ready(rdy1), .hash_out(ho1), .hash_valid(hv1),
        .hash_ready(hash_ready), .busy(bz1));
    sha2_stream_hasher #(.IN_BYTES(8), .LEN_W(16)) dut8 (
        .clk(clk), .rst(rst), .enable(enable), .mode_224(mode_224),
        .s_data(s_data), .s_nbytes(s_nbytes), .s_valid(s_valid && sel == 2),
        .s_last(s_last), .s_ready(rdy8), .hash_out(ho8), .hash_valid(hv8),
        .hash_ready(hash_ready), .busy(bz8));

    assign rdy_m = (sel == 0) ? rdy4 : (sel == 1) ? rdy1 : rdy8;
    assign hv_m  = (sel == 0) ? hv4  : (sel == 1) ? hv1  : hv8;
    assign bz_m  = (sel == 0) ? bz4  : (sel == 1) ? bz1  : bz8;
    assign ho_m  = (sel == 0) ? ho4  : (sel == 1) ? ho1  : ho8;

    localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    localparam logic [255:0] EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWOBLK = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    int           checks = 0, errors = 0;
    logic [7:0]   msg [64];
    logic [255:0] dq [$];
    logic [255:0] held;
    int           lat;

    // Digest handshakes completing at the next edge
    always @(negedge clk) begin
        #1;
        if (hv_m && hash_ready && enable && !rst) dq.push_back(ho_m);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < 64; i++) msg[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    // Returns just after the edge that accepts the last beat
    task automatic send_msg(input int len, input bit gaps);
        int bw, nbeats, n, guard;
        bw = (sel == 0) ? 4 : (sel == 1) ? 1 : 8;
        nbeats = (len == 0) ? 1 : (len + bw - 1) / bw;
        for (int b = 0; b < nbeats; b++) begin
            n = len - b * bw;
            if (n > bw) n = bw;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(negedge clk); s_valid = 1'b0; end
            @(negedge clk);
            s_data = '0;
            for (int j = 0; j < n; j++) s_data[8*(bw-1-j) +: 8] = msg[b*bw+j];
            s_nbytes = 4'(n);
            s_last   = (b == nbeats - 1);
            s_valid  = 1'b1;
            guard    = 0;
            forever begin
                if (gaps) enable = ($urandom_range(0, 3) != 0);
                #1;
                if (rdy_m) break;
                if (guard > 400) begin
                    checks++; errors++;
                    $error("FAIL ready_timeout observed=%0d expected=<400", guard);
                    break;
                end
                @(negedge clk);
                guard++;
            end
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
    endtask

    task automatic wait_digest(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            #1;
            if (hv_m || cyc > 600) break;
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic ack();
        @(negedge clk); hash_ready = 1'b1;
        @(negedge clk); hash_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 256'(rdy4), 256'd0);
        chk("rst_hash_valid", 256'(hv4), 256'd0);
        chk("rst_hash_out", ho4, 256'd0);
        chk("rst_busy", 256'(bz4), 256'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_s_ready", 256'(rdy4), 256'd1);

        // SHA-256 "abc": latency, hold without hash_ready
        load_str("abc");
        send_msg(3, 1'b0);
        wait_digest(lat);
        chk("abc256_latency", 256'(lat), 256'd66);
        chk("abc256_digest", ho4, ABC256);
        chk("abc256_busy", 256'(bz4), 256'd1);
        held = ho4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("hold_valid_%0d", i), 256'(hv4), 256'd1);
            chk($sformatf("hold_out_%0d", i), ho4, held);
        end
        ack();
        #1;
        chk("ack_hash_valid", 256'(hv4), 256'd0);
        chk("ack_busy", 256'(bz4), 256'd0);
        chk("ack_s_ready", 256'(rdy4), 256'd1);

        // SHA-224 "abc"
        mode_224 = 1'b1;
        send_msg(3, 1'b0);
        wait_digest(lat);
        chk("abc224_digest", ho4, ABC224);
        ack();

        // Empty message
        mode_224 = 1'b0;
        send_msg(0, 1'b0);
        wait_digest(lat);
        chk("empty_latency", 256'(lat), 256'd66);
        chk("empty_digest", ho4, EMPTY);
        ack();

        // Two-block 56-byte message on each beat width
        load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        for (int s = 0; s < 3; s++) begin
            sel = s;
            send_msg(56, 1'b0);
            wait_digest(lat);
            chk($sformatf("twoblk_latency_sel%0d", s), 256'(lat), 256'd132);
            chk($sformatf("twoblk_digest_sel%0d", s), ho_m, TWOBLK);
            ack();
        end
        sel = 0;

        // Back-to-back with gaps and enable stalls
        load_str("abc");
        dq.delete();
        hash_ready = 1'b1;
        mode_224 = 1'b0;
        send_msg(3, 1'b1);
        mode_224 = 1'b1;
        send_msg(3, 1'b1);
        @(negedge clk); s_valid = 1'b0; s_last = 1'b0;
        for (int i = 0; i < 300 && dq.size() < 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("b2b_count", 256'(dq.size()), 256'd2);
        if (dq.size() >= 2) begin
            chk("b2b_first", dq[0], ABC256);
            chk("b2b_second", dq[1], ABC224);
        end

        // Reset during round ~30 aborts the message
        dq.delete();
        mode_224 = 1'b0;
        send_msg(3, 1'b0);
        repeat (31) @(posedge clk);
        @(negedge clk); s_valid = 1'b0; s_last = 1'b0; rst = 1'b1;
        #1;
        chk("abort_s_ready", 256'(rdy4), 256'd0);
        chk("abort_hash_valid", 256'(hv4), 256'd0);
        chk("abort_hash_out", ho4, 256'd0);
        chk("abort_busy", 256'(bz4), 256'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        chk("abort_post_s_ready", 256'(rdy4), 256'd1);
        send_msg(3, 1'b0);
        wait_digest(lat);
        repeat (3) @(negedge clk);
        chk("abort_count", 256'(dq.size()), 256'd1);
        if (dq.size() >= 1) chk("abort_digest", dq[0], ABC256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
